// File: rtl/windowed_frame_ingester_pkg.sv
// Shared types and width helpers for the windowed camera ingester.
package windowed_frame_ingester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int x_width(input int max_width);
    return cnt_width(max_width);
  endfunction

  function automatic int y_width(input int max_height);
    return cnt_width(max_height);
  endfunction

endpackage

// File: rtl/windowed_frame_ingester_sync.sv
// Multi-flop synchroniser with an aligned level output and registered rise/fall strobes.
module sync_edge_detect #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clock) begin
    if (!reset) begin
      chain <= '0;
      level <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
    end
  end

  // Edges are registered so they line up with the level output on the same cycle.
  generate
    if (EDGES) begin : g_edges
      always_ff @(posedge clock) begin
        if (!reset) begin
          rise <= '0;
          fall <= '0;
        end else begin
          rise <= chain[STAGES-1] & ~level;
          fall <= ~chain[STAGES-1] & level;
        end
      end
    end else begin : g_no_edges
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

endmodule

// File: rtl/windowed_frame_ingester.sv
// Camera bus ingester: sync-driven pixel/line counting, programmable crop window, markers and error flags.
module windowed_frame_ingester
  import windowed_frame_ingester_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_WIDTH       = 640,
  parameter int MAX_HEIGHT      = 480,
  parameter int SYNC_STAGES     = 2,
  parameter int FRAME_CNT_WIDTH = 16,
  localparam int XW = x_width(MAX_WIDTH),
  localparam int YW = y_width(MAX_HEIGHT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      cam_pixdata,
  input  logic                       cam_pixclk,
  input  logic                       cam_hsync,
  input  logic                       cam_vsync,
  input  logic [XW-1:0]              cfg_x_start,
  input  logic [XW-1:0]              cfg_x_end,
  input  logic [YW-1:0]              cfg_y_start,
  input  logic [YW-1:0]              cfg_y_end,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_sof,
  output logic                       out_last,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       err_short_line,
  output logic                       err_short_frame,
  output logic                       err_cfg
);

  localparam logic [XW-1:0] X_MAX = XW'(MAX_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAX_HEIGHT - 1);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_N = SW'(SETTLE);

  logic [2:0] ctrl_level, ctrl_rise, ctrl_fall;
  logic [DATA_WIDTH-1:0] data, data_rise_unused, data_fall_unused;

  sync_edge_detect #(.WIDTH(3), .STAGES(SYNC_STAGES), .EDGES(1'b1)) u_ctrl_sync (
    .clock(clock), .reset(reset),
    .din({cam_vsync, cam_hsync, cam_pixclk}),
    .level(ctrl_level), .rise(ctrl_rise), .fall(ctrl_fall)
  );

  sync_edge_detect #(.WIDTH(DATA_WIDTH), .STAGES(SYNC_STAGES), .EDGES(1'b0)) u_data_sync (
    .clock(clock), .reset(reset),
    .din(cam_pixdata),
    .level(data), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  logic pix_rise, hs, hs_fall, vs, vs_rise, vs_fall, unused_ctrl;
  assign pix_rise    = ctrl_rise[0];
  assign hs          = ctrl_level[1];
  assign hs_fall     = ctrl_fall[1];
  assign vs          = ctrl_level[2];
  assign vs_rise     = ctrl_rise[2];
  assign vs_fall     = ctrl_fall[2];
  assign unused_ctrl = ^{ctrl_level[0], ctrl_rise[1], ctrl_fall[0]};

  state_t state_q, state_d;
  logic [SW-1:0] settle_cnt;
  logic armed;
  logic [XW-1:0] x, xs_sh, xe_sh;
  logic [YW-1:0] y, ys_sh, ye_sh;
  logic suppress, last_seen, line_end_seen;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_ARMED;
      ST_ARMED:  if (vs_rise && armed) state_d = ST_ACTIVE;
      ST_ACTIVE: if (vs_fall) state_d = ST_ARMED;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic frame_start, in_active, frame_end, pix_take, line_adv;
  logic x_in, y_in, emit, at_first, at_last, line_done, cfg_bad;

  assign frame_start = (state_q == ST_ARMED) && vs_rise && armed;
  assign in_active   = (state_q == ST_ACTIVE);
  assign frame_end   = in_active && vs_fall;
  // Frame end dominates: no pixel or line event is acted on in the same cycle.
  assign pix_take    = in_active && !vs_fall && pix_rise && hs && vs;
  assign line_adv    = in_active && !vs_fall && hs_fall;
  assign x_in        = (x >= xs_sh) && (x <= xe_sh);
  assign y_in        = (y >= ys_sh) && (y <= ye_sh);
  assign emit        = pix_take && x_in && y_in && !suppress;
  assign at_first    = (x == xs_sh) && (y == ys_sh);
  assign at_last     = (x == xe_sh) && (y == ye_sh);
  assign line_done   = line_end_seen || (pix_take && (x == xe_sh));
  assign cfg_bad     = (cfg_x_start > cfg_x_end) || (cfg_y_start > cfg_y_end) ||
                       (cfg_x_end > X_MAX) || (cfg_y_end > Y_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      settle_cnt      <= '0;
      armed           <= 1'b0;
      x               <= '0;
      y               <= '0;
      xs_sh           <= '0;
      xe_sh           <= '0;
      ys_sh           <= '0;
      ye_sh           <= '0;
      suppress        <= 1'b0;
      last_seen       <= 1'b0;
      line_end_seen   <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_sof         <= 1'b0;
      out_last        <= 1'b0;
      frame_count     <= '0;
      err_short_line  <= 1'b0;
      err_short_frame <= 1'b0;
      err_cfg         <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && at_first;
      out_last  <= emit && at_last;
      if (emit) out_data <= data;

      // Only arm once the synchroniser reflects the pins and vsync is seen low,
      // so a frame in flight at reset release is dropped.
      if (settle_cnt != SETTLE_N) settle_cnt <= settle_cnt + 1'b1;
      if ((settle_cnt == SETTLE_N) && !vs) armed <= 1'b1;

      if (frame_start) begin
        xs_sh         <= cfg_x_start;
        xe_sh         <= cfg_x_end;
        ys_sh         <= cfg_y_start;
        ye_sh         <= cfg_y_end;
        x             <= '0;
        y             <= '0;
        suppress      <= cfg_bad;
        last_seen     <= 1'b0;
        line_end_seen <= 1'b0;
        if (cfg_bad) err_cfg <= 1'b1;
      end

      if (pix_take) begin
        if (x != X_MAX) x <= x + 1'b1;
        if (x == xe_sh) line_end_seen <= 1'b1;
        if (emit && at_last) last_seen <= 1'b1;
      end

      if (line_adv) begin
        x             <= '0;
        line_end_seen <= 1'b0;
        if (y != Y_MAX) y <= y + 1'b1;
        if (y_in && !line_done) err_short_line <= 1'b1;
      end

      if (frame_end) begin
        frame_count <= frame_count + 1'b1;
        if (!suppress && !last_seen) err_short_frame <= 1'b1;
      end
    end
  end

endmodule

// File: doc/windowed_frame_ingester.md
Name: windowed_frame_ingester

Overview:
- Parametrised successor to the fixed-geometry camera ingester.
- Synchronises a parallel camera bus (pixclk/hsync/vsync/data) into the system clock domain and counts pixels and lines from the sync signals rather than from fixed padding.
- Emits only pixels inside a runtime-programmable crop window, with start-of-frame and last-pixel markers.
- Sits between the camera pins and the downsampler / frame-end stuffer chain; adds sticky error flags and a frame counter.

Parameters:
- DATA_WIDTH, 8, pixel bus width.
- MAX_WIDTH, 640, maximum pixels per line; sets the x counter width XW = $clog2(MAX_WIDTH).
- MAX_HEIGHT, 480, maximum lines per frame; sets the y counter width YW = $clog2(MAX_HEIGHT).
- SYNC_STAGES, 2, synchroniser depth (>=2) applied to pixclk, hsync, vsync and data alike.
- FRAME_CNT_WIDTH, 16, width of frame_count.

Ports:
- clock  in  1  system clock, >=6x pixclk.
- reset  in  1  synchronous, active-low.
- cam_pixdata  in  DATA_WIDTH  raw camera data.
- cam_pixclk  in  1  raw camera pixel clock.
- cam_hsync  in  1  line valid, active-high.
- cam_vsync  in  1  frame valid, active-high.
- cfg_x_start  in  XW  first column kept, inclusive.
- cfg_x_end  in  XW  last column kept, inclusive.
- cfg_y_start  in  YW  first line kept, inclusive.
- cfg_y_end  in  YW  last line kept, inclusive.
- out_valid  out  1  one-cycle strobe; out_data is valid.
- out_data  out  DATA_WIDTH  cropped pixel.
- out_sof  out  1  qualifies the first window pixel of a frame.
- out_last  out  1  qualifies the last window pixel of a frame.
- frame_count  out  FRAME_CNT_WIDTH  completed frames, wraps.
- err_short_line  out  1  sticky error flag.
- err_short_frame  out  1  sticky error flag.
- err_cfg  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at a clock edge) clears:
  - all synchroniser stages;
  - x/y counters, the shadow window and the armed flag;
  - out_valid, out_data, out_sof, out_last (all 0);
  - frame_count (0) and all err_* flags (0).
- Synchronisers: every camera input passes through SYNC_STAGES flops, so data stays aligned with the sync signals.
- Edge detection on the last two stages of each synchronised signal: pix_rise, hs_fall, vs_rise, vs_fall.
- States: IDLE (after reset), ARMED (waiting for frame), ACTIVE (frame in progress).
  - IDLE->ARMED on the first clock out of reset.
  - ARMED->ACTIVE on vs_rise.
  - ACTIVE->ARMED on vs_fall.
  - A frame already in progress when reset is released is discarded entirely; no output until the next vs_rise.
- On vs_rise: latch cfg_* into shadow registers and zero x and y. Cfg changes mid-frame have no effect until the next vs_rise.
- Config check at latch time. If any of these hold, set err_cfg and suppress all output for that frame (counting continues):
  - start > end on either axis;
  - x_end >= MAX_WIDTH;
  - y_end >= MAX_HEIGHT.
- Pixel sampling: on pix_rise with hs and vs both synchronised high in ACTIVE, sample the synchronised data at column x, then x <= x+1.
  - x saturates at MAX_WIDTH-1; no wrap.
- Line advance: on hs_fall in ACTIVE, x <= 0 and y <= y+1.
  - y saturates at MAX_HEIGHT-1.
  - If y was within [y_start, y_end] and x <= x_end (that line's last window column was never sampled), set err_short_line.
- Output: a sample is emitted when x in [x_start, x_end] and y in [y_start, y_end].
  - Registered output: out_valid high exactly one clock after the clock on which pix_rise was detected.
  - Total latency from a raw cam_pixclk rising edge to out_valid is SYNC_STAGES+2 clocks.
- Markers:
  - out_sof = out_valid && x==x_start && y==y_start.
  - out_last = out_valid && x==x_end && y==y_end.
  - Single-pixel window: both asserted on the same strobe.
- Frame end: on vs_fall in ACTIVE, frame_count <= frame_count+1, wrapping at all-ones.
  - If the frame was not suppressed and out_last never fired this frame, set err_short_frame.
- Simultaneous events:
  - hs_fall and pix_rise on the same clock: the pixel is sampled at the old x first, then x <= 0.
  - vs_fall with any other event: frame end wins; no pixel is emitted.
- Error flags are sticky until reset.

Decomposition:
- Package windowed_frame_ingester_pkg holds:
  - state encoding (ST_IDLE, ST_ARMED, ST_ACTIVE);
  - the width helper functions for XW and YW.
- Sub-module sync_edge_detect (parameter WIDTH, STAGES): the synchroniser chain plus rise/fall outputs. Instantiate it once for the control signals and once, edge-less, for data.

Test Plan:
- 6x4 frame, window x 1..3, y 1..2 -> exactly 6 out_valid strobes carrying pixel values (y*6+x) for x 1..3, y 1..2. out_sof on value 7, out_last on value 15; frame_count 0->1 after vsync falls.
- Window rewritten mid-frame to x 0..0 -> current frame still uses 1..3; the next frame emits one pixel per line for lines 1..2.
- cfg_x_start=4, cfg_x_end=2 -> err_cfg=1, zero strobes that frame, frame_count still increments.
- Line 1 cut to 2 pixels (hsync drops early) with window x 1..3 -> err_short_line=1. vsync then falls before y=2 completes -> err_short_frame=1; both stay high until reset is asserted.
- Reset asserted mid-line for 3 clocks and released while vsync is high -> no output for the rest of that frame; the next frame outputs normally with frame_count counting from 0.
- Single-pixel window x 5..5, y 3..3 -> one strobe with out_sof=out_last=1; latency from cam_pixclk edge measured = SYNC_STAGES+2 clocks.
